// File: rtl/mouse_transmitter_if.sv
// Command-side and pad-side signals of the PS/2 host-to-device transmitter.
// master = mouse master FSM plus pad inputs; slave = the transmitter itself.
interface mouse_transmitter_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       CLK_MOUSE_OUT_EN;
  logic       DATA_MOUSE_OUT;
  logic       DATA_MOUSE_OUT_EN;
  logic       BUSY;
  logic       BYTE_SENT;
  logic [1:0] BYTE_ERROR_CODE;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, CLK_MOUSE_IN, DATA_MOUSE_IN,
    input  CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN,
           BUSY, BYTE_SENT, BYTE_ERROR_CODE
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, CLK_MOUSE_IN, DATA_MOUSE_IN,
    output CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN,
           BUSY, BYTE_SENT, BYTE_ERROR_CODE
  );
endinterface

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: sends one command byte to the mouse over
// the shared open-drain clock/data pads, reporting timeout / missing ACK.
//   state        | meaning
//   S_IDLE       | lines released, waiting for SEND_BYTE
//   S_CLK_HOLD   | pulling mouse clock low (request-to-send)
//   S_DATA_SETUP | clock still low, data driven 0 (start bit)
//   S_SEND       | clock released, shifting data/parity/stop on device edges
//   S_WAIT_ACK   | waiting for the ACK falling edge
//   S_WAIT_IDLE  | waiting for both lines to return high
//   S_DONE       | BYTE_SENT pulse, back to idle
module mouse_transmitter #(
  parameter int T_CLK_HOLD   = 5000,
  parameter int T_DATA_SETUP = 100,
  parameter int T_TIMEOUT    = 50000
) (
  input logic               CLK,
  input logic               RESETN,
  mouse_transmitter_if.slave bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLK_HOLD   = 3'd1;
  localparam logic [2:0] S_DATA_SETUP = 3'd2;
  localparam logic [2:0] S_SEND       = 3'd3;
  localparam logic [2:0] S_WAIT_ACK   = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE  = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam logic [15:0] HOLD_LOAD  = 16'(T_CLK_HOLD - 1);
  localparam logic [15:0] SETUP_LOAD = 16'(T_DATA_SETUP - 1);
  localparam logic [15:0] TO_LOAD    = 16'(T_TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] phase_tmr;
  logic [15:0] to_tmr;
  logic [3:0]  bit_cnt;
  logic [7:0]  byte_q;
  logic        parity_q;
  logic        clk_s1, clk_s2, clk_prev;
  logic        data_s1, data_s2;
  logic        dev_fall;

  logic        clk_en_q;
  logic        data_out_q;
  logic        data_en_q;
  logic        busy_q;
  logic        byte_sent_q;
  logic [1:0]  err_q;

  assign dev_fall = clk_prev & ~clk_s2;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= S_IDLE;
      phase_tmr   <= '0;
      to_tmr      <= '0;
      bit_cnt     <= '0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      clk_prev    <= 1'b1;
      data_s1     <= 1'b1;
      data_s2     <= 1'b1;
      clk_en_q    <= 1'b0;
      data_out_q  <= 1'b1;
      data_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      byte_sent_q <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      clk_s1      <= bus.CLK_MOUSE_IN;
      clk_s2      <= clk_s1;
      clk_prev    <= clk_s2;
      data_s1     <= bus.DATA_MOUSE_IN;
      data_s2     <= data_s1;
      byte_sent_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.SEND_BYTE) begin
            byte_q    <= bus.BYTE_TO_SEND;
            parity_q  <= ~^bus.BYTE_TO_SEND;
            err_q     <= 2'b00;
            bit_cnt   <= '0;
            phase_tmr <= HOLD_LOAD;
            clk_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            state     <= S_CLK_HOLD;
          end
        end

        S_CLK_HOLD: begin
          if (phase_tmr == 16'd0) begin
            phase_tmr  <= SETUP_LOAD;
            data_en_q  <= 1'b1;
            data_out_q <= 1'b0;
            state      <= S_DATA_SETUP;
          end else begin
            phase_tmr <= phase_tmr - 16'd1;
          end
        end

        S_DATA_SETUP: begin
          if (phase_tmr == 16'd0) begin
            clk_en_q <= 1'b0;
            to_tmr   <= TO_LOAD;
            state    <= S_SEND;
          end else begin
            phase_tmr <= phase_tmr - 16'd1;
          end
        end

        S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
          if (dev_fall) to_tmr <= TO_LOAD;
          else          to_tmr <= to_tmr - 16'd1;

          // A device edge in the terminal cycle still counts as activity.
          if (!dev_fall && to_tmr == 16'd0) begin
            err_q[0]    <= 1'b1;
            clk_en_q    <= 1'b0;
            data_en_q   <= 1'b0;
            data_out_q  <= 1'b1;
            byte_sent_q <= 1'b1;
            state       <= S_DONE;
          end else if (state == S_SEND) begin
            if (dev_fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt < 4'd8) begin
                data_out_q <= byte_q[bit_cnt[2:0]];
              end else if (bit_cnt == 4'd8) begin
                data_out_q <= parity_q;
              end else begin
                data_en_q  <= 1'b0;
                data_out_q <= 1'b1;
                state      <= S_WAIT_ACK;
              end
            end
          end else if (state == S_WAIT_ACK) begin
            if (dev_fall) begin
              if (data_s2) err_q[1] <= 1'b1;
              state <= S_WAIT_IDLE;
            end
          end else begin
            if (clk_s2 && data_s2) begin
              byte_sent_q <= 1'b1;
              state       <= S_DONE;
            end
          end
        end

        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.CLK_MOUSE_OUT_EN  = clk_en_q;
  assign bus.DATA_MOUSE_OUT    = data_out_q;
  assign bus.DATA_MOUSE_OUT_EN = data_en_q;
  assign bus.BUSY              = busy_q;
  assign bus.BYTE_SENT         = byte_sent_q;
  assign bus.BYTE_ERROR_CODE   = err_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Self-checking bench for mouse_transmitter: a behavioural PS/2 device model
// clocks bytes out of the host and the captured frame is compared to the byte.
module tb_mouse_transmitter;
  localparam int T_HOLD  = 50;
  localparam int T_SETUP = 10;
  localparam int T_TMO   = 1500;
  localparam int HALF    = 40;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int n_chk = 0;
  int n_bad = 0;
  int sent_cnt = 0;
  logic [1:0] last_code = 2'b00;
  logic       last_busy = 1'b0;
  logic [1:0] last_en = 2'b00;

  mouse_transmitter_if bus();

  assign bus.CLK_MOUSE_IN  = ~(bus.CLK_MOUSE_OUT_EN | dev_clk_low);
  assign bus.DATA_MOUSE_IN = bus.DATA_MOUSE_OUT_EN ? bus.DATA_MOUSE_OUT : ~dev_data_low;

  mouse_transmitter #(
    .T_CLK_HOLD(T_HOLD),
    .T_DATA_SETUP(T_SETUP),
    .T_TIMEOUT(T_TMO)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RESETN && bus.BYTE_SENT) begin
      sent_cnt  <= sent_cnt + 1;
      last_code <= bus.BYTE_ERROR_CODE;
      last_busy <= bus.BUSY;
      last_en   <= {bus.CLK_MOUSE_OUT_EN, bus.DATA_MOUSE_OUT_EN};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host transfer against the device model. n_edges: falling edges the
  // device generates; ack: device pulls data low at edge 11; poke: stray
  // request while busy; rst_at: assert reset in the low phase of that edge.
  task automatic xfer(input logic [7:0] b, input int n_edges, input bit ack,
                      input bit poke, input int rst_at);
    int cnt;
    int base;
    logic [11:0] smp;
    logic [1:0] exp_code;
    logic [31:0] exp_bit;
    smp  = '0;
    base = sent_cnt;

    @(negedge CLK);
    bus.SEND_BYTE    = 1'b1;
    bus.BYTE_TO_SEND = b;
    @(negedge CLK);
    bus.SEND_BYTE    = 1'b0;
    bus.BYTE_TO_SEND = 8'($urandom);
    chk("busy_on", bus.BUSY, 1);
    chk("clk_hold_on", bus.CLK_MOUSE_OUT_EN, 1);

    cnt = 1;
    while (!bus.DATA_MOUSE_OUT_EN && cnt < T_HOLD + 20) begin
      @(negedge CLK);
      cnt++;
    end
    chk("clk_hold_len", cnt - 1, T_HOLD);
    chk("start_bit_drv", bus.DATA_MOUSE_OUT, 0);
    chk("clk_held_in_setup", bus.CLK_MOUSE_OUT_EN, 1);

    cnt = 0;
    while (bus.CLK_MOUSE_OUT_EN && cnt < T_SETUP + 20) begin
      @(negedge CLK);
      cnt++;
    end
    chk("data_setup_len", cnt, T_SETUP);
    chk("start_bit_pad", bus.DATA_MOUSE_IN, 0);

    for (int k = 1; k <= n_edges; k++) begin
      repeat (HALF) @(negedge CLK);
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge CLK);
      end
      dev_clk_low = 1'b1;
      if (poke && k == 3) begin
        @(negedge CLK);
        bus.SEND_BYTE    = 1'b1;
        bus.BYTE_TO_SEND = 8'hAA;
        @(negedge CLK);
        bus.SEND_BYTE    = 1'b0;
      end
      if (k == rst_at) begin
        repeat (10) @(negedge CLK);
        RESETN = 1'b0;
        #1;
        chk("rst_clk_released", bus.CLK_MOUSE_OUT_EN, 0);
        chk("rst_data_released", bus.DATA_MOUSE_OUT_EN, 0);
        chk("rst_busy_low", bus.BUSY, 0);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge CLK);
        RESETN = 1'b1;
        repeat (10) @(negedge CLK);
        chk("rst_no_byte_sent", sent_cnt - base, 0);
        return;
      end
      repeat (HALF) @(negedge CLK);
      smp[k] = bus.DATA_MOUSE_IN;
      dev_clk_low = 1'b0;
      if (k == 11) dev_data_low = 1'b0;
    end

    cnt = 0;
    while (sent_cnt == base && cnt < T_TMO + 200) begin
      @(negedge CLK);
      cnt++;
    end
    chk("byte_sent_seen", (sent_cnt != base), 1);
    if (n_edges == 0)
      chk("timeout_latency", (cnt >= T_TMO - 1 && cnt <= T_TMO + 3), 1);

    repeat (20) @(negedge CLK);
    if (n_edges < 11)  exp_code = 2'b01;
    else if (!ack)     exp_code = 2'b10;
    else               exp_code = 2'b00;
    chk("single_pulse", sent_cnt - base, 1);
    chk("error_code", last_code, exp_code);
    chk("busy_during_pulse", last_busy, 1);
    chk("lines_released_at_pulse", last_en, 0);
    chk("busy_off", bus.BUSY, 0);
    chk("code_held", bus.BYTE_ERROR_CODE, exp_code);

    for (int k = 1; k <= n_edges && k <= 10; k++) begin
      if (k <= 8)      exp_bit = (32'(b) >> (k - 1)) & 32'd1;
      else if (k == 9) exp_bit = ($countones(b) % 2 == 0) ? 32'd1 : 32'd0;
      else             exp_bit = 32'd1;
      chk($sformatf("frame_bit%0d_byte%02h", k, b), smp[k], exp_bit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SEND_BYTE    = 1'b0;
    bus.BYTE_TO_SEND = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_clk_en", bus.CLK_MOUSE_OUT_EN, 0);
    chk("rst_data_out", bus.DATA_MOUSE_OUT, 1);
    chk("rst_data_en", bus.DATA_MOUSE_OUT_EN, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_byte_sent", bus.BYTE_SENT, 0);
    chk("rst_err", bus.BYTE_ERROR_CODE, 0);
    RESETN = 1'b1;
    repeat (5) @(negedge CLK);

    xfer(8'hF4, 11, 1'b1, 1'b0, 0);
    xfer(8'hFF, 11, 1'b1, 1'b0, 0);
    xfer(8'h00, 11, 1'b0, 1'b0, 0);
    xfer(8'h5A, 0,  1'b1, 1'b0, 0);
    xfer(8'h3C, 4,  1'b1, 1'b0, 0);
    xfer(8'hF4, 11, 1'b1, 1'b1, 0);
    xfer(8'h81, 11, 1'b1, 1'b0, 5);
    xfer(8'hF6, 11, 1'b1, 1'b0, 0);
    for (int r = 0; r < 6; r++)
      xfer(8'($urandom), 11, ($urandom_range(0, 3) != 0), 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
